// File: rtl/femtorv_seq_alu.sv
// Sequential RISC-V ALU for shifts (coarse-stepped) and the M extension (shift-add multiply, restoring divide).
// Latency: done in cycle N+1+k after the accepting edge N; k = shamt/SHIFT_STEP + shamt%SHIFT_STEP, XLEN for mul/div, 0 for trivial cases.
// Backpressure: start is only honoured while busy_o=0 (IDLE or the done cycle); flush_i aborts, reset_i dominates everything.
// Ports: clk_i, reset_i (sync, active-high), start_i, flush_i, op_i[4:0] = {muldiv, instr[30], funct3},
//        in1_i/in2_i operands; busy_o (iterating), done_o (one-cycle result strobe), result_o (held until the next completion).
module femtorv_seq_alu #(
  parameter int XLEN          = 32,
  parameter int SHIFT_STEP    = 4,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [SHW-1:0] STEP_W = SHW'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
  typedef enum logic [2:0] {K_NONE, K_SLL, K_SRL, K_SRA, K_MUL, K_DIV} kind_t;

  state_t              state_q;
  kind_t               kind_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q;
  logic [XLEN-1:0]     result_q;
  logic [XLEN-1:0]     sh_q;
  logic [SHW-1:0]      shamt_q;
  logic [2*XLEN-1:0]   mcand_q, prod_q;
  logic [XLEN-1:0]     mplier_q, prem_q, quo_q, dvsr_q;
  logic                neg_q, rneg_q, sel_q;

  // ---------------- request decode (only consumed on an accepting edge)
  kind_t           kind_in;
  logic [SHW-1:0]  shamt_in;
  logic [CW-1:0]   k_in;
  logic            a_sgn, b_sgn, a_neg, b_neg, sel_in;
  logic [XLEN-1:0] a_mag, b_mag, imm_res;

  always_comb begin
    kind_in  = K_NONE;
    shamt_in = in2_i[SHW-1:0];
    if (op_i[4]) begin
      // op[3] carries no meaning for M ops
      if (ENABLE_MULDIV) kind_in = op_i[2] ? K_DIV : K_MUL;
    end else begin
      case (op_i[3:0])
        4'b0001: kind_in = K_SLL;
        4'b0101: kind_in = K_SRL;
        4'b1101: kind_in = K_SRA;
        default: kind_in = K_NONE;
      endcase
    end

    // Mul: MULH signs both, MULHSU signs rs1 only. Div: signed unless funct3[0].
    if (kind_in == K_MUL) begin
      a_sgn  = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
      b_sgn  = (op_i[1:0] == 2'b01);
      sel_in = (op_i[1:0] != 2'b00);
    end else begin
      a_sgn  = ~op_i[0];
      b_sgn  = ~op_i[0];
      sel_in = op_i[1];
    end
    a_neg = a_sgn & in1_i[XLEN-1];
    b_neg = b_sgn & in2_i[XLEN-1];
    a_mag = a_neg ? -in1_i : in1_i;
    b_mag = b_neg ? -in2_i : in2_i;

    case (kind_in)
      K_SLL, K_SRL, K_SRA: k_in = CW'(shamt_in / STEP_W) + CW'(shamt_in % STEP_W);
      K_MUL:               k_in = CW'(XLEN);
      K_DIV:               k_in = (in2_i == '0) ? '0 : CW'(XLEN);
      default:             k_in = '0;
    endcase

    // Result for the k=0 cases: zero shift, divide by zero, invalid op.
    case (kind_in)
      K_SLL, K_SRL, K_SRA: imm_res = in1_i;
      K_DIV:               imm_res = sel_in ? in1_i : '1;
      default:             imm_res = '0;
    endcase
  end

  // ---------------- one iteration of the active datapath
  logic [SHW-1:0]    step, shamt_d;
  logic [XLEN-1:0]   sh_d, mplier_d, prem_d, quo_d, quo_f, rem_f, iter_res;
  logic [2*XLEN-1:0] mcand_d, prod_d, prod_f;
  logic [XLEN:0]     trial, diff;

  always_comb begin
    step     = (shamt_q >= STEP_W) ? STEP_W : SHW'(1);
    sh_d     = sh_q;
    shamt_d  = shamt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    prem_d   = prem_q;
    quo_d    = quo_q;
    trial    = {prem_q, quo_q[XLEN-1]};
    diff     = trial - {1'b0, dvsr_q};
    case (kind_q)
      K_SLL: begin sh_d = sh_q << step; shamt_d = shamt_q - step; end
      K_SRL: begin sh_d = sh_q >> step; shamt_d = shamt_q - step; end
      K_SRA: begin sh_d = $unsigned($signed(sh_q) >>> step); shamt_d = shamt_q - step; end
      K_MUL: begin
        prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      K_DIV: begin
        // Restoring step: keep the trial subtraction only if it did not go negative.
        if (trial >= {1'b0, dvsr_q}) begin
          prem_d = diff[XLEN-1:0];
          quo_d  = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          prem_d = trial[XLEN-1:0];
          quo_d  = {quo_q[XLEN-2:0], 1'b0};
        end
      end
      default: ;
    endcase

    prod_f = neg_q  ? -prod_d : prod_d;
    quo_f  = neg_q  ? -quo_d  : quo_d;
    rem_f  = rneg_q ? -prem_d : prem_d;
    case (kind_q)
      K_SLL, K_SRL, K_SRA: iter_res = sh_d;
      K_MUL:               iter_res = sel_q ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0];
      K_DIV:               iter_res = sel_q ? rem_f : quo_f;
      default:             iter_res = '0;
    endcase
  end

  // ---------------- control FSM and all state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sh_q     <= '0;
      shamt_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      prem_q   <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          sh_q     <= sh_d;
          shamt_q  <= shamt_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          prod_q   <= prod_d;
          prem_q   <= prem_d;
          quo_q    <= quo_d;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= S_FINISH;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= iter_res;
          end
        end
        default: begin
          // IDLE and FINISH both accept, which gives bubble-free back-to-back ops.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start_i) begin
            kind_q   <= kind_in;
            cnt_q    <= k_in;
            sh_q     <= in1_i;
            shamt_q  <= shamt_in;
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
            prod_q   <= '0;
            prem_q   <= '0;
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            sel_q    <= sel_in;
            if (k_in == '0) begin
              state_q  <= S_FINISH;
              done_q   <= 1'b1;
              result_q <= imm_res;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_femtorv_seq_alu.sv
// Randomised and directed bench for femtorv_seq_alu (XLEN=32, SHIFT_STEP=4), with a second
// instance built without the M extension. Expected results come from 64-bit integer arithmetic.
module tb_femtorv_seq_alu;

  logic        clk = 1'b0;
  logic        reset, start, dis_start, flush;
  logic [4:0]  op;
  logic [31:0] in1, in2;
  logic        busy, done, dis_busy, dis_done;
  logic [31:0] result, dis_result;

  always #5 clk = ~clk;

  femtorv_seq_alu #(.XLEN(32), .SHIFT_STEP(4), .ENABLE_MULDIV(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .flush_i(flush), .op_i(op),
    .in1_i(in1), .in2_i(in2), .busy_o(busy), .done_o(done), .result_o(result)
  );

  femtorv_seq_alu #(.XLEN(32), .SHIFT_STEP(4), .ENABLE_MULDIV(1'b0)) dut_nomd (
    .clk_i(clk), .reset_i(reset), .start_i(dis_start), .flush_i(flush), .op_i(op),
    .in1_i(in1), .in2_i(in2), .busy_o(dis_busy), .done_o(dis_done), .result_o(dis_result)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Iteration count straight from the latency rules.
  function automatic int ref_k(input logic [4:0] o, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (o == 5'b00001 || o == 5'b00101 || o == 5'b01101) return sh / 4 + sh % 4;
    if (o[4]) return (o[2] && b == 32'd0) ? 0 : 32;
    return 0;
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (o == 5'b00001) return a << b[4:0];
    if (o == 5'b00101) return a >> b[4:0];
    if (o == 5'b01101) return $unsigned($signed(a) >>> b[4:0]);
    if (!o[4]) return 32'd0;
    case (o[2:0])
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Called at a negedge with the DUT able to accept. Returns at the negedge of the done cycle
  // (chain=1, so the caller may start again right there) or one cycle later (chain=0).
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit chain, input bit poke);
    int          k, nb, dcyc;
    logic [31:0] exp;
    k    = ref_k(o, b);
    exp  = ref_res(o, a, b);
    nb   = 0;
    dcyc = 0;
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 100 && dcyc == 0; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb++;
      if (done) dcyc = j;
      else if (busy && poke && j == 2) begin
        // A request during RUN must not disturb the operation in flight.
        start = 1'b1;
        op    = 5'($urandom);
        in1   = $urandom;
        in2   = $urandom;
      end
    end
    chk({tag, "_done_cycle"}, 64'(dcyc), 64'(k + 1));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(k));
    chk({tag, "_result"}, 64'(result), 64'(exp));
    if (!chain) begin
      @(negedge clk);
      chk({tag, "_single_pulse"}, 64'({busy, done}), 64'd0);
      chk({tag, "_result_held"}, 64'(result), 64'(exp));
    end
  endtask

  task automatic abort_test(input bit use_reset, input string tag);
    logic [31:0] prev;
    bit          seen;
    prev = result;
    seen = 1'b0;
    op = 5'b10101; in1 = $urandom; in2 = $urandom | 32'd1; start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, "_busy_before"}, 64'(busy), 64'd1);
    if (use_reset) reset = 1'b1;
    else           flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(result), use_reset ? 64'd0 : 64'(prev));
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev;
    bit          seen;
    logic [4:0]  ro;
    int          r;

    reset = 1'b1; start = 1'b0; dis_start = 1'b0; flush = 1'b0;
    op = '0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Coarse shift with a remainder tail.
    do_op(5'b01101, 32'h8000_0000, 32'd7, "sra_7", 1'b0, 1'b0);
    // Zero shift, then a start in the done cycle.
    do_op(5'b00001, 32'h1234_5678, 32'd0, "sll_0", 1'b1, 1'b0);
    do_op(5'b00101, 32'hF000_0000, 32'd5, "srl_b2b", 1'b0, 1'b0);
    // High multiply words.
    do_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh", 1'b0, 1'b1);
    do_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", 1'b0, 1'b0);
    // Division corners.
    do_op(5'b10100, 32'd7, 32'd0, "div_by0", 1'b0, 1'b0);
    do_op(5'b10110, 32'hFFFF_FFF9, 32'd2, "rem_neg", 1'b0, 1'b0);
    do_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1, 1'b0);
    do_op(5'b11110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf_b2b", 1'b0, 1'b0);
    do_op(5'b10111, 32'd1234, 32'd0, "remu_by0", 1'b0, 1'b0);
    // Invalid op with a non-zero previous result.
    do_op(5'b00000, 32'hDEAD_BEEF, 32'd3, "invalid", 1'b0, 1'b0);

    abort_test(1'b0, "flush");
    abort_test(1'b1, "reset");

    // flush beats a simultaneous start.
    do_op(5'b00001, 32'h0000_00A5, 32'd4, "pre_fs", 1'b0, 1'b0);
    prev = result;
    seen = 1'b0;
    op = 5'b10000; in1 = 32'd3; in2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush_start_no_done", 64'(seen), 64'd0);
    chk("flush_start_result", 64'(result), 64'(prev));

    // M ops are invalid without the extension.
    op = 5'b00001; in1 = 32'd5; in2 = 32'd0; dis_start = 1'b1;
    @(negedge clk);
    dis_start = 1'b0;
    chk("nomd_sll_done", 64'(dis_done), 64'd1);
    chk("nomd_sll_result", 64'(dis_result), 64'd5);
    op = 5'b10000; in1 = 32'd6; in2 = 32'd7; dis_start = 1'b1;
    @(negedge clk);
    dis_start = 1'b0;
    chk("nomd_mul_done", 64'(dis_done), 64'd1);
    chk("nomd_mul_busy", 64'(dis_busy), 64'd0);
    chk("nomd_mul_result", 64'(dis_result), 64'd0);
    @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        case ($urandom_range(0, 2))
          0:       ro = 5'b00001;
          1:       ro = 5'b00101;
          default: ro = 5'b01101;
        endcase
      end else if (r < 8) begin
        ro = {1'b1, 4'($urandom)};
      end else begin
        ro = 5'($urandom);
      end
      do_op(ro, pick_operand(), pick_operand(), $sformatf("rnd%0d_op%b", i, ro),
            1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/femtorv_seq_alu.md
FEMTORV_SEQ_ALU -- requirements
Module: femtorv_seq_alu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 32 and 64.
REQ-002 Parameter SHIFT_STEP, default 4: coarse shift step in bits; legal values 1, 2, 4 and 8.
REQ-003 Parameter ENABLE_MULDIV, default 1: when 0, M-extension ops are treated as invalid ops.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request; sampled only while busy=0.
REQ-007 flush  in  1  aborts the operation in flight.
REQ-008 op  in  5  {muldiv, arith, funct3}; op[3] is instr[30], op[2:0] is funct3.
REQ-009 in1  in  XLEN  rs1 operand.
REQ-010 in2  in  XLEN  rs2 operand or immediate.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle pulse; result valid.
REQ-013 result  out  XLEN  registered result; held until the next accepted start.

Function
REQ-014 The block shall accept a request on any rising edge where start=1, busy=0 and flush=0, capturing op, in1 and in2; edge N denotes that accepting edge.
REQ-015 start while busy=1 shall be ignored with no state change.
REQ-016 The block shall have the states IDLE, RUN and FINISH: accept -> RUN if k>0, else FINISH; RUN -> FINISH when the remaining count reaches 0; FINISH -> IDLE, or -> accept if start=1.
REQ-017 busy shall be 1 exactly in RUN; done shall be 1 exactly in FINISH, for one cycle; result shall update on entry to FINISH.
REQ-018 With k iteration cycles, done shall be high in cycle N+1+k.
REQ-019 A start accepted while done=1 shall be legal, giving back-to-back operation with no bubble.
REQ-020 Shifts (op 00001 SLL, 00101 SRL, 01101 SRA) shall take shamt = in2[log2(XLEN)-1:0].
REQ-021 Each shift iteration cycle shall shift by SHIFT_STEP while remaining >= SHIFT_STEP, else by 1.
REQ-022 A shift shall take k = shamt/SHIFT_STEP + shamt%SHIFT_STEP iteration cycles.
REQ-023 SRA shall fill with in1[XLEN-1]; SLL and SRL shall fill with 0.
REQ-024 MUL, MULH, MULHSU and MULHU (op 1x000..1x011) shall use a radix-2 shift-add over a 2*XLEN-bit product with k=XLEN.
REQ-025 Signed multiply operands shall be sign-corrected per RISC-V; MUL shall return the low XLEN bits and the others the high XLEN bits.
REQ-026 DIV, DIVU, REM and REMU (op 1x100..1x111) shall use restoring division on magnitudes with k=XLEN, then apply sign fixup: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-027 Division by zero shall take k=0 and return quotient all-ones and remainder in1.
REQ-028 Signed overflow (in1 = -2^(XLEN-1), in2 = -1) shall return quotient in1 and remainder 0 with k=XLEN.
REQ-029 op[3] shall be ignored when op[4]=1.
REQ-030 Any other op, or any M op with ENABLE_MULDIV=0, shall take k=0 and return result 0.
REQ-031 flush=1 shall force IDLE on the next edge with done=0 and result unchanged.
REQ-032 flush shall take priority over start; a start in the same cycle as flush shall be dropped.
REQ-033 Outputs shall depend only on registered state, with no combinational path from any input to any output.

Reset
REQ-034 reset=1 at a rising edge shall force IDLE, busy=0, done=0, result=0 and clear all internal counters and operand registers.
REQ-035 reset shall take priority over flush and start, including mid-operation; no done shall follow a reset.
REQ-036 Outputs shall be undefined before the first reset edge.

Verification
REQ-037 Shift: SHIFT_STEP=4, SRA, in1=0x80000000, in2=7 -> k=4, busy high for 4 cycles, done in cycle N+5, result=0xFF000000.
REQ-038 Shift, zero amount: SLL with in2=0 -> done in cycle N+1, busy never high, result=in1; issue a second start in the done cycle and check it completes correctly.
REQ-039 Multiply: MULH, in1=0xFFFFFFFF, in2=0xFFFFFFFF -> done in cycle N+33, result=0x00000000; MULHU on the same operands -> result 0xFFFFFFFE.
REQ-040 Division corners: DIV 7/0 -> done in cycle N+1, result=0xFFFFFFFF; REM -7/2 -> result 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> result 0x80000000.
REQ-041 Abort and reset: flush in cycle N+10 of a DIVU -> IDLE next cycle, no done pulse, result unchanged; repeat with reset instead -> result=0.
REQ-042 Invalid and disabled ops: op=00000 -> done in cycle N+1 with result=0; with ENABLE_MULDIV=0, MUL -> result=0.
